// File: rtl/contador_flancos.sv
// Edge-event up/down counter with load, clear, one-cycle wrap pulse and sticky overflow.
// Define CONTADOR_SATURATE_EN to hold the count at the boundary instead of wrapping.
module contador_flancos #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iFlancoP,
  input  logic             iFlancoN,
  input  logic             iFlancoX,
  input  logic [1:0]       iModo,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadValue,
  input  logic             iClear,
  output logic [WIDTH-1:0] oCount,
  output logic             oWrap,
  output logic             oOverflow
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             ovf_r;

  logic             event_s;
  logic             boundary_s;
  logic [WIDTH-1:0] stepped_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             ovf_nxt_s;

  // Event source selection; hold mode produces no events.
  always_comb begin
    event_s = 1'b0;
    case (iModo)
      2'b00:   event_s = iFlancoP;
      2'b01:   event_s = iFlancoN;
      2'b10:   event_s = iFlancoX;
      2'b11:   event_s = 1'b0;
      default: event_s = 1'b0;
    endcase
  end

  // Boundary detection and the wrapped/saturated one-step value.
  always_comb begin
    boundary_s = 1'b0;
    stepped_s  = count_r;
    if (iUp) begin
      boundary_s = (count_r == CNT_MAX);
      stepped_s  = count_r + CNT_ONE;
    end else begin
      boundary_s = (count_r == CNT_ZERO);
      stepped_s  = count_r - CNT_ONE;
    end
`ifdef CONTADOR_SATURATE_EN
    if (boundary_s) begin
      stepped_s = count_r;
    end else begin
      stepped_s = stepped_s;
    end
`endif
  end

  // Next-state selection: clear beats load, load beats a count event.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    ovf_nxt_s   = ovf_r;
    if (iClear) begin
      count_nxt_s = CNT_ZERO;
      ovf_nxt_s   = 1'b0;
    end else if (iLoad) begin
      count_nxt_s = iLoadValue;
    end else if (event_s) begin
      count_nxt_s = stepped_s;
      if (boundary_s) begin
        wrap_nxt_s = 1'b1;
        ovf_nxt_s  = 1'b1;
      end else begin
        wrap_nxt_s = 1'b0;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iReset) begin
      count_r <= CNT_ZERO;
      wrap_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign oCount    = count_r;
  assign oWrap     = wrap_r;
  assign oOverflow = ovf_r;

endmodule

// File: tb/tb_contador_flancos.sv
// Directed self-checking bench for contador_flancos (WIDTH=8); expectations follow CONTADOR_SATURATE_EN.
module tb_contador_flancos;

  logic       iClk = 1'b0;
  logic       iReset;
  logic       iFlancoP;
  logic       iFlancoN;
  logic       iFlancoX;
  logic [1:0] iModo;
  logic       iUp;
  logic       iLoad;
  logic [7:0] iLoadValue;
  logic       iClear;
  logic [7:0] oCount;
  logic       oWrap;
  logic       oOverflow;

  int n_total = 0;
  int n_bad   = 0;

`ifdef CONTADOR_SATURATE_EN
  localparam logic [7:0] UP_BOUND_EXP = 8'hFF;
  localparam logic [7:0] DN_BOUND_EXP = 8'h00;
`else
  localparam logic [7:0] UP_BOUND_EXP = 8'h00;
  localparam logic [7:0] DN_BOUND_EXP = 8'hFF;
`endif

  contador_flancos #(.WIDTH(8)) dut (
    .iClk(iClk), .iReset(iReset), .iFlancoP(iFlancoP), .iFlancoN(iFlancoN),
    .iFlancoX(iFlancoX), .iModo(iModo), .iUp(iUp), .iLoad(iLoad),
    .iLoadValue(iLoadValue), .iClear(iClear), .oCount(oCount), .oWrap(oWrap),
    .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulses(input logic p, input logic n, input logic x);
    iFlancoP = p; iFlancoN = n; iFlancoX = x;
  endtask

  initial begin
    iReset = 1'b0; pulses(1'b0, 1'b0, 1'b0);
    iModo = 2'b00; iUp = 1'b1; iLoad = 1'b0; iLoadValue = 8'h00; iClear = 1'b0;

    // reset state
    step();
    check_val("rst_count", oCount, 8'h00);
    check_val("rst_wrap", oWrap, 1'b0);
    check_val("rst_ovf", oOverflow, 1'b0);

    // P counting with interleaved N pulses; first event at first edge with reset high
    iReset = 1'b1;
    pulses(1'b1, 1'b0, 1'b0); step(); check_val("p1", oCount, 8'd1);
    pulses(1'b0, 1'b1, 1'b0); step(); check_val("n_ignored1", oCount, 8'd1);
    pulses(1'b1, 1'b0, 1'b0); step(); check_val("p2", oCount, 8'd2);
    pulses(1'b0, 1'b1, 1'b1); step(); check_val("nx_ignored", oCount, 8'd2);
    pulses(1'b1, 1'b0, 1'b0); step(); check_val("p3", oCount, 8'd3);
    check_val("p3_wrap", oWrap, 1'b0);

    // up boundary via X
    pulses(1'b0, 1'b0, 1'b0);
    iLoad = 1'b1; iLoadValue = 8'd254; step(); check_val("load254", oCount, 8'd254);
    iLoad = 1'b0; iModo = 2'b10; iUp = 1'b1;
    pulses(1'b0, 1'b0, 1'b1); step();
    check_val("up255", oCount, 8'd255);
    check_val("up255_wrap", oWrap, 1'b0);
    check_val("up255_ovf", oOverflow, 1'b0);
    step();
    check_val("up_bound", oCount, UP_BOUND_EXP);
    check_val("up_bound_wrap", oWrap, 1'b1);
    check_val("up_bound_ovf", oOverflow, 1'b1);
    pulses(1'b0, 1'b0, 1'b0); step();
    check_val("up_after_wrap", oWrap, 1'b0);
    check_val("up_after_ovf", oOverflow, 1'b1);
    check_val("up_after_count", oCount, UP_BOUND_EXP);

    // down boundary via N; load keeps overflow
    iUp = 1'b0; iModo = 2'b01;
    iLoad = 1'b1; iLoadValue = 8'd1; step();
    check_val("load1", oCount, 8'd1);
    check_val("load1_ovf", oOverflow, 1'b1);
    iLoad = 1'b0;
    pulses(1'b0, 1'b1, 1'b0); step();
    check_val("dn0", oCount, 8'd0);
    check_val("dn0_wrap", oWrap, 1'b0);
    step();
    check_val("dn_bound", oCount, DN_BOUND_EXP);
    check_val("dn_bound_wrap", oWrap, 1'b1);
    pulses(1'b0, 1'b0, 1'b0); step();
    check_val("dn_after_wrap", oWrap, 1'b0);

    // priority: clear over load over event
    iModo = 2'b10; iUp = 1'b1;
    iClear = 1'b1; iLoad = 1'b1; iLoadValue = 8'h5A; pulses(1'b0, 1'b0, 1'b1); step();
    check_val("clr_count", oCount, 8'h00);
    check_val("clr_ovf", oOverflow, 1'b0);
    check_val("clr_wrap", oWrap, 1'b0);
    iClear = 1'b0; step();
    check_val("load_over_evt", oCount, 8'h5A);
    check_val("load_over_evt_wrap", oWrap, 1'b0);

    // set overflow again, then hold mode
    iLoadValue = 8'hFF; step(); iLoad = 1'b0; step();
    check_val("re_bound_ovf", oOverflow, 1'b1);
    iModo = 2'b11; pulses(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step();
    check_val("hold_count", oCount, UP_BOUND_EXP);
    check_val("hold_wrap", oWrap, 1'b0);

    // reset with coincident event
    iModo = 2'b10; iReset = 1'b0; step();
    check_val("rst_evt_count", oCount, 8'h00);
    check_val("rst_evt_wrap", oWrap, 1'b0);
    check_val("rst_evt_ovf", oOverflow, 1'b0);

    // back-to-back X events
    iReset = 1'b1; pulses(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_val("b2b", oCount, 32'(i));
    end

    // same-cycle mode/direction changes
    iModo = 2'b00; pulses(1'b0, 1'b0, 1'b1); step();
    check_val("mode_switch_ignore_x", oCount, 8'd5);
    iUp = 1'b0; pulses(1'b1, 1'b0, 1'b0); step();
    check_val("dir_switch_down", oCount, 8'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/contador_flancos.md
CONTADOR_FLANCOS -- requirements
Module: contador_flancos

Interface
REQ-001 Parameter WIDTH, default 8, sets the counter width in bits.
REQ-002 iClk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 iReset  input  1  synchronous, active-low reset, sampled on the iClk rising edge.
REQ-004 iFlancoP  input  1  one-cycle pulse marking a rising edge from the edge-detector stage.
REQ-005 iFlancoN  input  1  one-cycle pulse marking a falling edge from the edge-detector stage.
REQ-006 iFlancoX  input  1  one-cycle pulse marking any edge from the edge-detector stage.
REQ-007 iModo  input  2  event source select: 00 = P, 01 = N, 10 = X, 11 = hold (no counting).
REQ-008 iUp  input  1  count direction: 1 = increment, 0 = decrement.
REQ-009 iLoad  input  1  synchronous load of iLoadValue.
REQ-010 iLoadValue  input  WIDTH  value to load.
REQ-011 iClear  input  1  synchronous clear of the count and flags.
REQ-012 oCount  output  WIDTH  registered count.
REQ-013 oWrap  output  1  registered one-cycle pulse on a boundary event.
REQ-014 oOverflow  output  1  registered sticky boundary flag.

Function
REQ-015 Count event: the iFlanco input chosen by iModo, sampled high on an iClk rising edge; iModo=11 SHALL produce no events.
REQ-016 Latency: each count event SHALL change oCount by exactly 1 on that same rising edge, so the new value is visible in the following cycle.
REQ-017 Input priority each cycle SHALL be: reset, then iClear, then iLoad, then count event.
REQ-018 iClear SHALL set oCount=0, oWrap=0 and oOverflow=0, and SHALL drop any coincident load or event.
REQ-019 iLoad SHALL set oCount=iLoadValue and oWrap=0, SHALL leave oOverflow unchanged, and SHALL drop any coincident event.
REQ-020 Up event at 2^WIDTH-1 and down event at 0 are boundary events; the Configuration section defines their effect on oCount.
REQ-021 A boundary event SHALL assert oWrap for exactly one cycle and SHALL set oOverflow=1.
REQ-022 In all other cycles oWrap SHALL be 0.
REQ-023 oOverflow SHALL stay at 1 until iClear or reset.
REQ-024 Changes to iModo and iUp SHALL take effect in the same cycle they are sampled, with no pipeline of the selection.
REQ-025 Back-to-back events on consecutive cycles SHALL each be counted; the block SHALL have no dead cycles.
REQ-026 Pulses on non-selected iFlanco inputs SHALL be ignored.

Reset
REQ-027 When iReset=0 at a rising edge: oCount=0, oWrap=0, oOverflow=0, and all other inputs are ignored.
REQ-028 Reset asserted during counting SHALL discard any event in that cycle.
REQ-029 The first event counted after reset is one sampled at the first edge with iReset=1.

Configuration
REQ-030 Macro CONTADOR_SATURATE_EN selects saturating versus wrapping behaviour at the boundaries.
REQ-031 With CONTADOR_SATURATE_EN undefined, a boundary event SHALL wrap modulo 2^WIDTH: 255->0 up, 0->255 down for WIDTH=8.
REQ-032 With CONTADOR_SATURATE_EN defined, a boundary event SHALL hold oCount at its current value, 255 or 0.
REQ-033 In saturating mode, oWrap and oOverflow SHALL still behave per REQ-021 to REQ-023.

Verification
REQ-034 Reset then select: iReset=0 one cycle, then iModo=00, iUp=1, three iFlancoP pulses -> oCount=3; interleaved iFlancoN pulses do not change oCount.
REQ-035 Up boundary: load 254 with iLoad, then two iFlancoX pulses (iModo=10, iUp=1) -> oCount=255 then 0 (wrap build) or 255 (CONTADOR_SATURATE_EN build); oWrap one pulse on the second event; oOverflow=1 until iClear.
REQ-036 Down boundary: load 1 with iUp=0 and iModo=01, then two iFlancoN pulses -> oCount=0 then 255 (wrap build) or 0 (saturate build); oWrap one pulse.
REQ-037 Priority: iClear, iLoad=1 with iLoadValue=8'h5A, and a selected event all in one cycle -> oCount=0, oOverflow=0; next cycle iLoad with an event -> oCount=8'h5A.
REQ-038 Hold and reset: iModo=11 with 10 pulses on every iFlanco input -> oCount unchanged; then iReset=0 coincident with an event -> oCount=0, oWrap=0.
REQ-039 Back-to-back: iFlancoX high for 5 consecutive cycles with iModo=10, iUp=1 from 0 -> oCount=5.
